keypad_entry_display: RTL and testbench
=======================================

# keypad_entry_display

Parametrised numeric-entry front end that sits directly behind `KeyboardDecoder`. It turns PS/2 key presses into a right-aligned BCD entry buffer of `DIGITS` digits, handles backspace/clear/enter editing, and drives a time-multiplexed, active-low seven-segment display of the buffer. It generalises the single-code `last_change` display path to multi-digit entry with editing and a selectable overflow mode.

## Interface

- `DIGITS`, 4: number of buffer digits and display digits (2..8).
- `REFRESH_BITS`, 17: the digit-scan advances every 2^`REFRESH_BITS` clk cycles (≥1).
- `OVERWRITE`, 0: full-buffer policy. 0 drops new digits. 1 shifts the oldest digit out.
- `clk` in 1: system clock; the only clock.
- `rst` in 1: reset, asynchronous, active-low (asserted when 0).
- `key_valid` in 1: decoder event strobe (level; rising edge is the event).
- `last_change` in 9: scan code of the latest event; bit 8 = E0-extended.
- `key_down` in 512: per-code pressed state from the decoder.
- `display` out 8: active-low segments {a,b,c,d,e,f,g,dp}; dp always 1.
- `ctrl` out `DIGITS`: active-low digit enables, exactly one bit 0 after reset.
- `value` out 4*`DIGITS`: BCD buffer; digit 0 (least significant) in [3:0].
- `count` out $clog2(`DIGITS`+1): number of digits entered.
- `full` out 1: `count` == `DIGITS`.
- `enter` out 1: one-cycle pulse on Enter.

## Operation

- Press detect: `kv_q` registers `key_valid`. An event is `key_valid & ~kv_q & key_down[last_change]`. Releases (key_down bit 0) are ignored. The event is registered into `evt`/`evt_code` on the cycle after the edge.
- Digit codes (9'h0xx): main row 0–9 = 45,16,1E,26,25,2E,36,3D,3E,46; keypad 0–9 = 70,69,72,7A,6B,73,74,6C,75,7D. Extended variants (bit 8 = 1) are not digits.
- Digit, `count` < `DIGITS`: `value` <= {value[4*DIGITS-5:0], d}; `count`++.
- Digit, full, `OVERWRITE`=0: no change.
- Digit, full, `OVERWRITE`=1: same shift; the oldest digit is discarded; `count` stays at `DIGITS`.
- Backspace 9'h066: if `count` > 0, then `value` <= value >> 4 and `count`--. If `count` is 0, no change.
- Escape 9'h076: `value` <= 0 and `count` <= 0.
- Enter 9'h05A or 9'h15A: `enter` = 1 for one cycle. The buffer is held, not cleared.
- All other codes: ignored.
- Display: `scan_cnt` (REFRESH_BITS wide) free-runs. On wrap, `digit_idx` advances 0..`DIGITS`-1 and then wraps to 0.
- `ctrl` = ~(1 << digit_idx).
- `display` shows the glyph of `value` nibble[digit_idx] when digit_idx < `count`. Otherwise it shows blank (8'hFF), so leading positions are dark.
- Glyphs (active-low, dp=1): 0=03, 1=9F, 2=25, 3=0D, 4=99, 5=49, 6=41, 7=1F, 8=01, 9=09 (hex).
- Nibbles are always 0–9; there is no glyph for other values.
- `display` and `ctrl` are registered.

## Timing

- Reset (`rst`=0, asynchronous) forces:
  - `value`=0, `count`=0, `full`=0, `enter`=0;
  - `kv_q`=0, `scan_cnt`=0, `digit_idx`=0;
  - `ctrl`={all 1 except bit0=0}, `display`=8'hFF.
- Release is synchronous to clk. Reset mid-entry discards the buffer.
- Latency: `key_valid` rises at cycle N. `evt` is set at N+1. `value`/`count`/`full`/`enter` update at N+2.
- `display` reflects new data at the next register update for that digit, within 2^REFRESH_BITS·DIGITS + 1 cycles.
- Only one event is processed per `key_valid` rising edge. Holding `key_valid` high (typematic) produces no repeat. Repeats need a new edge.
- Edges spaced ≥2 cycles apart are all processed in order. There is no queueing beyond one event.
- `full` and `count` are combinationally consistent with `value` in every cycle.

## Test plan

- Reset, then a 1-cycle `key_valid` pulse with `last_change`=9'h016 and key_down[16]=1 → at N+2 `value`=16'h0001, `count`=1. With REFRESH_BITS=2, `ctrl`=4'b1110 and `display`=8'h9F while digit 0 is scanned; digits 1–3 show 8'hFF.
- DIGITS=4, OVERWRITE=0: enter 1,2,3,4,5 → `value`=16'h1234, `count`=4, `full`=1. Repeat with OVERWRITE=1 → `value`=16'h2345, `full`=1.
- From 16'h1234, press Backspace twice → `value`=16'h0012, `count`=2. Then Escape → `value`=0, `count`=0. Backspace when empty → no change.
- Keypad 7 (9'h06C), then Enter, then keypad Enter (9'h15A) → `value`=16'h0007. `enter` pulses exactly twice, one cycle each. Extended 9'h16C is ignored.
- Release event (key_down bit 0) and `key_valid` held high for 10 cycles → at most one update, none for the release.
- Assert `rst`=0 asynchronously mid-scan with `count`=3 → outputs go to their reset values immediately, with no clk edge required.

Source files
------------

// File: rtl/keypad_entry_display.sv
// Numeric entry front end behind a PS/2 keyboard decoder: right-aligned BCD
// buffer with backspace/clear/enter editing and a multiplexed 7-segment display.
module keypad_entry_display #(
    parameter int DIGITS       = 4,
    parameter int REFRESH_BITS = 17,
    parameter bit OVERWRITE    = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          key_valid,
    input  logic [8:0]                    last_change,
    input  logic [511:0]                  key_down,
    output logic [7:0]                    display,
    output logic [DIGITS-1:0]             ctrl,
    output logic [4*DIGITS-1:0]           value,
    output logic [$clog2(DIGITS+1)-1:0]   count,
    output logic                          full,
    output logic                          enter
);
    localparam int CW = $clog2(DIGITS + 1);
    localparam int IW = $clog2(DIGITS);
    localparam int VW = 4 * DIGITS;
    localparam logic [CW-1:0]     FULL_CNT = CW'(DIGITS);
    localparam logic [IW-1:0]     LAST_IDX = IW'(DIGITS - 1);
    localparam logic [DIGITS-1:0] ONE_HOT0 = {{(DIGITS-1){1'b0}}, 1'b1};

    localparam logic [8:0] CODE_BKSP  = 9'h066;
    localparam logic [8:0] CODE_ESC   = 9'h076;
    localparam logic [8:0] CODE_ENT   = 9'h05A;
    localparam logic [8:0] CODE_ENT_X = 9'h15A;

    // Returns {is_digit, bcd} for a scan code; extended codes are never digits.
    function automatic logic [4:0] decode_digit(input logic [8:0] code);
        logic [4:0] r;
        case (code)
            9'h045, 9'h070: r = 5'h10;
            9'h016, 9'h069: r = 5'h11;
            9'h01E, 9'h072: r = 5'h12;
            9'h026, 9'h07A: r = 5'h13;
            9'h025, 9'h06B: r = 5'h14;
            9'h02E, 9'h073: r = 5'h15;
            9'h036, 9'h074: r = 5'h16;
            9'h03D, 9'h06C: r = 5'h17;
            9'h03E, 9'h075: r = 5'h18;
            9'h046, 9'h07D: r = 5'h19;
            default:        r = 5'h00;
        endcase
        return r;
    endfunction

    // Active-low segment pattern {a..g,dp}, dp always off.
    function automatic logic [7:0] glyph(input logic [3:0] d);
        logic [7:0] g;
        case (d)
            4'd0:    g = 8'h03;
            4'd1:    g = 8'h9F;
            4'd2:    g = 8'h25;
            4'd3:    g = 8'h0D;
            4'd4:    g = 8'h99;
            4'd5:    g = 8'h49;
            4'd6:    g = 8'h41;
            4'd7:    g = 8'h1F;
            4'd8:    g = 8'h01;
            4'd9:    g = 8'h09;
            default: g = 8'hFF;
        endcase
        return g;
    endfunction

    logic                    kv_q, kv_d;
    logic                    evt_q, evt_d;
    logic [8:0]              evt_code_q, evt_code_d;
    logic [VW-1:0]           value_q, value_d;
    logic [CW-1:0]           count_q, count_d;
    logic                    enter_q, enter_d;
    logic [REFRESH_BITS-1:0] scan_cnt_q, scan_cnt_d;
    logic [IW-1:0]           digit_idx_q, digit_idx_d;
    logic [DIGITS-1:0]       ctrl_q, ctrl_d;
    logic [7:0]              display_q, display_d;
    logic [4:0]              dec_s;
    logic                    full_s;

    assign full_s = (count_q == FULL_CNT);
    assign dec_s  = decode_digit(evt_code_q);

    // Next-state logic: press detect, buffer editing and display scan.
    always_comb begin
        kv_d        = key_valid;
        evt_d       = key_valid & ~kv_q & key_down[last_change];
        evt_code_d  = last_change;
        value_d     = value_q;
        count_d     = count_q;
        enter_d     = 1'b0;
        scan_cnt_d  = scan_cnt_q + 1'b1;
        digit_idx_d = digit_idx_q;

        if (evt_q) begin
            if (dec_s[4]) begin
                if (!full_s) begin
                    value_d = {value_q[VW-5:0], dec_s[3:0]};
                    count_d = count_q + 1'b1;
                end else if (OVERWRITE) begin
                    value_d = {value_q[VW-5:0], dec_s[3:0]};
                end else begin
                    value_d = value_q;
                end
            end else if (evt_code_q == CODE_BKSP) begin
                if (count_q != {CW{1'b0}}) begin
                    value_d = value_q >> 4;
                    count_d = count_q - 1'b1;
                end else begin
                    value_d = value_q;
                end
            end else if (evt_code_q == CODE_ESC) begin
                value_d = {VW{1'b0}};
                count_d = {CW{1'b0}};
            end else if ((evt_code_q == CODE_ENT) || (evt_code_q == CODE_ENT_X)) begin
                enter_d = 1'b1;
            end else begin
                enter_d = 1'b0;
            end
        end else begin
            enter_d = 1'b0;
        end

        if (&scan_cnt_q) begin
            digit_idx_d = (digit_idx_q == LAST_IDX) ? {IW{1'b0}} : digit_idx_q + 1'b1;
        end else begin
            digit_idx_d = digit_idx_q;
        end

        ctrl_d = ~(ONE_HOT0 << digit_idx_q);
        // Positions beyond the entered digits stay dark.
        if (CW'(digit_idx_q) < count_q) begin
            display_d = glyph(value_q[digit_idx_q*4 +: 4]);
        end else begin
            display_d = 8'hFF;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            kv_q        <= 1'b0;
            evt_q       <= 1'b0;
            evt_code_q  <= 9'h000;
            value_q     <= {VW{1'b0}};
            count_q     <= {CW{1'b0}};
            enter_q     <= 1'b0;
            scan_cnt_q  <= {REFRESH_BITS{1'b0}};
            digit_idx_q <= {IW{1'b0}};
            ctrl_q      <= ~ONE_HOT0;
            display_q   <= 8'hFF;
        end else begin
            kv_q        <= kv_d;
            evt_q       <= evt_d;
            evt_code_q  <= evt_code_d;
            value_q     <= value_d;
            count_q     <= count_d;
            enter_q     <= enter_d;
            scan_cnt_q  <= scan_cnt_d;
            digit_idx_q <= digit_idx_d;
            ctrl_q      <= ctrl_d;
            display_q   <= display_d;
        end
    end

    assign value   = value_q;
    assign count   = count_q;
    assign full    = full_s;
    assign enter   = enter_q;
    assign ctrl    = ctrl_q;
    assign display = display_q;

endmodule

// File: tb/tb_keypad_entry_display.sv
// Directed bench for keypad_entry_display: one instance per overflow policy,
// both driven from the same key stream.
module tb_keypad_entry_display;
    logic         clk;
    logic         rst;
    logic         key_valid;
    logic [8:0]   last_change;
    logic [511:0] key_down;

    logic [7:0]  display0, display1;
    logic [3:0]  ctrl0, ctrl1;
    logic [15:0] value0, value1;
    logic [2:0]  count0, count1;
    logic        full0, full1, enter0, enter1;

    int n_cmp  = 0;
    int n_fail = 0;
    int enter_cnt = 0;

    keypad_entry_display #(.DIGITS(4), .REFRESH_BITS(2), .OVERWRITE(1'b0)) dut0 (
        .clk(clk), .rst(rst), .key_valid(key_valid), .last_change(last_change),
        .key_down(key_down), .display(display0), .ctrl(ctrl0), .value(value0),
        .count(count0), .full(full0), .enter(enter0)
    );

    keypad_entry_display #(.DIGITS(4), .REFRESH_BITS(2), .OVERWRITE(1'b1)) dut1 (
        .clk(clk), .rst(rst), .key_valid(key_valid), .last_change(last_change),
        .key_down(key_down), .display(display1), .ctrl(ctrl1), .value(value1),
        .count(count1), .full(full1), .enter(enter1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts cycles in which the enter pulse is high.
    always @(negedge clk) begin
        if (enter0 === 1'b1) enter_cnt <= enter_cnt + 1;
    end

    // One key press: key_valid high for one cycle; returns once the buffer has updated.
    task automatic press(input logic [8:0] code);
        @(negedge clk);
        key_valid = 1'b1;
        last_change = code;
        key_down[code] = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        @(negedge clk);
        key_down[code] = 1'b0;
    endtask

    task automatic wait_ctrl(input logic [3:0] pat);
        int k;
        k = 0;
        while (ctrl0 !== pat && k < 64) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (ctrl0 !== pat) begin
            n_fail++;
            $display("FAIL scan_ctrl: got %b want %b", ctrl0, pat);
        end
    endtask

    task automatic test_reset;
        n_cmp += 6;
        if (value0 !== 16'h0000) begin n_fail++; $display("FAIL rst_value: got %h want 0000", value0); end
        if (count0 !== 3'd0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", count0); end
        if (full0 !== 1'b0) begin n_fail++; $display("FAIL rst_full: got %b want 0", full0); end
        if (enter0 !== 1'b0) begin n_fail++; $display("FAIL rst_enter: got %b want 0", enter0); end
        if (ctrl0 !== 4'b1110) begin n_fail++; $display("FAIL rst_ctrl: got %b want 1110", ctrl0); end
        if (display0 !== 8'hFF) begin n_fail++; $display("FAIL rst_display: got %h want FF", display0); end
    endtask

    task automatic test_first_digit;
        @(negedge clk);
        key_valid = 1'b1;
        last_change = 9'h016;
        key_down[9'h016] = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (value0 !== 16'h0000) begin n_fail++; $display("FAIL latency_n1: got %h want 0000", value0); end
        key_valid = 1'b0;
        @(negedge clk);
        key_down[9'h016] = 1'b0;
        n_cmp += 2;
        if (value0 !== 16'h0001) begin n_fail++; $display("FAIL first_value: got %h want 0001", value0); end
        if (count0 !== 3'd1) begin n_fail++; $display("FAIL first_count: got %0d want 1", count0); end
        @(negedge clk);
        wait_ctrl(4'b1110);
        n_cmp++;
        if (display0 !== 8'h9F) begin n_fail++; $display("FAIL disp_d0: got %h want 9F", display0); end
        for (int i = 1; i < 4; i++) begin
            wait_ctrl(~(4'b0001 << i));
            n_cmp++;
            if (display0 !== 8'hFF) begin n_fail++; $display("FAIL disp_blank%0d: got %h want FF", i, display0); end
        end
    endtask

    task automatic test_full;
        press(9'h076);
        press(9'h016);
        press(9'h01E);
        press(9'h026);
        press(9'h025);
        press(9'h02E);
        n_cmp += 6;
        if (value0 !== 16'h1234) begin n_fail++; $display("FAIL drop_value: got %h want 1234", value0); end
        if (count0 !== 3'd4) begin n_fail++; $display("FAIL drop_count: got %0d want 4", count0); end
        if (full0 !== 1'b1) begin n_fail++; $display("FAIL drop_full: got %b want 1", full0); end
        if (value1 !== 16'h2345) begin n_fail++; $display("FAIL ovw_value: got %h want 2345", value1); end
        if (count1 !== 3'd4) begin n_fail++; $display("FAIL ovw_count: got %0d want 4", count1); end
        if (full1 !== 1'b1) begin n_fail++; $display("FAIL ovw_full: got %b want 1", full1); end
    endtask

    task automatic test_backspace;
        press(9'h066);
        press(9'h066);
        n_cmp += 3;
        if (value0 !== 16'h0012) begin n_fail++; $display("FAIL bksp_value: got %h want 0012", value0); end
        if (count0 !== 3'd2) begin n_fail++; $display("FAIL bksp_count: got %0d want 2", count0); end
        if (full0 !== 1'b0) begin n_fail++; $display("FAIL bksp_full: got %b want 0", full0); end
        press(9'h076);
        n_cmp += 2;
        if (value0 !== 16'h0000) begin n_fail++; $display("FAIL esc_value: got %h want 0000", value0); end
        if (count0 !== 3'd0) begin n_fail++; $display("FAIL esc_count: got %0d want 0", count0); end
        press(9'h066);
        n_cmp += 2;
        if (value0 !== 16'h0000) begin n_fail++; $display("FAIL bksp_empty_value: got %h want 0000", value0); end
        if (count0 !== 3'd0) begin n_fail++; $display("FAIL bksp_empty_count: got %0d want 0", count0); end
    endtask

    task automatic test_enter;
        int e0;
        e0 = enter_cnt;
        press(9'h06C);
        press(9'h05A);
        press(9'h15A);
        press(9'h16C);
        repeat (2) @(negedge clk);
        n_cmp += 3;
        if (value0 !== 16'h0007) begin n_fail++; $display("FAIL enter_value: got %h want 0007", value0); end
        if (count0 !== 3'd1) begin n_fail++; $display("FAIL enter_count: got %0d want 1", count0); end
        if (enter_cnt - e0 !== 2) begin n_fail++; $display("FAIL enter_pulses: got %0d want 2", enter_cnt - e0); end
    endtask

    task automatic test_release_typematic;
        press(9'h076);
        @(negedge clk);
        key_valid = 1'b1;
        last_change = 9'h016;
        key_down[9'h016] = 1'b0;
        @(negedge clk);
        key_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (count0 !== 3'd0) begin n_fail++; $display("FAIL release_count: got %0d want 0", count0); end
        key_valid = 1'b1;
        last_change = 9'h01E;
        key_down[9'h01E] = 1'b1;
        repeat (10) @(negedge clk);
        key_valid = 1'b0;
        key_down[9'h01E] = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp += 2;
        if (value0 !== 16'h0002) begin n_fail++; $display("FAIL typematic_value: got %h want 0002", value0); end
        if (count0 !== 3'd1) begin n_fail++; $display("FAIL typematic_count: got %0d want 1", count0); end
    endtask

    task automatic test_async_reset;
        press(9'h076);
        press(9'h016);
        press(9'h01E);
        press(9'h026);
        n_cmp++;
        if (count0 !== 3'd3) begin n_fail++; $display("FAIL pre_rst_count: got %0d want 3", count0); end
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        n_cmp += 6;
        if (value0 !== 16'h0000) begin n_fail++; $display("FAIL async_value: got %h want 0000", value0); end
        if (count0 !== 3'd0) begin n_fail++; $display("FAIL async_count: got %0d want 0", count0); end
        if (full0 !== 1'b0) begin n_fail++; $display("FAIL async_full: got %b want 0", full0); end
        if (ctrl0 !== 4'b1110) begin n_fail++; $display("FAIL async_ctrl: got %b want 1110", ctrl0); end
        if (display0 !== 8'hFF) begin n_fail++; $display("FAIL async_display: got %h want FF", display0); end
        if (value1 !== 16'h0000) begin n_fail++; $display("FAIL async_value_ovw: got %h want 0000", value1); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        key_valid = 1'b0;
        last_change = 9'h000;
        key_down = '0;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b1;
        test_first_digit();
        test_full();
        test_backspace();
        test_enter();
        test_release_typematic();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
